// File: rtl/ext_svn_seg_scan.sv
// ---------------------------------------------------------------------------
// ext_svn_seg_scan
//
// Time-multiplexed driver for a multi-digit seven-segment display. Each digit
// owns a slot of REFRESH_DIV clocks. The first GUARD_CYCLES clocks of every
// slot are all-off, which stops the previous digit ghosting into the next one.
// The rest of the slot drives the digit, gated by a free-running PWM counter
// for brightness and by the per-digit blank and blink controls.
//
// Display data is double-buffered. load_In captures the inputs into a shadow
// register, and the shadow moves to the active register only at a frame wrap,
// so a digit never changes in the middle of a frame.
//
// Optional feature, selected at build time:
//   SVN_SEG_LEAD_ZERO_BLANK_EN  defined   -> leading zeros without a dp are dark
//                               undefined -> every non-blanked digit is shown
//
// Ports:
//   clk            system clock
//   reset          asynchronous, active-high reset
//   bcd_In         hex nibble per digit; digit k = [4k+3:4k], digit 0 rightmost
//   dp_In          decimal point per digit
//   blank_In       force a digit dark
//   blink_In       digit blinks at the blink rate
//   load_In        strobe: capture the four data inputs into the shadow
//   brightness_In  PWM duty; all-ones = fully on, 0 = off
//   display_On     global enable; the scan keeps running while it is low
//   seg_Out        active-high segments, bit0=a .. bit6=g, bit7=dp (registered)
//   an_Out         active-high one-hot digit enable (registered)
//   frame_Out      one-cycle pulse at each frame wrap (registered)
// ---------------------------------------------------------------------------
module ext_svn_seg_scan #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int GUARD_CYCLES = 8,
  parameter int BRIGHT_W     = 4,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] bcd_In,
  input  logic [NUM_DIGITS-1:0]   dp_In,
  input  logic [NUM_DIGITS-1:0]   blank_In,
  input  logic [NUM_DIGITS-1:0]   blink_In,
  input  logic                    load_In,
  input  logic [BRIGHT_W-1:0]     brightness_In,
  input  logic                    display_On,
  output logic [7:0]              seg_Out,
  output logic [NUM_DIGITS-1:0]   an_Out,
  output logic                    frame_Out
);

  localparam int SLOT_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int DIGIT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(REFRESH_DIV - 1);
  localparam logic [SLOT_W-1:0]  GUARD_END  = SLOT_W'(GUARD_CYCLES);
  localparam logic [DIGIT_W-1:0] DIGIT_LAST = DIGIT_W'(NUM_DIGITS - 1);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(BLINK_FRAMES - 1);

  // Per-slot phase: all-off guard window, then the lit window.
  typedef enum logic {
    SLOT_GUARD = 1'b0,
    SLOT_LIT   = 1'b1
  } slot_state_e;

  localparam slot_state_e STATE_RST = (GUARD_CYCLES > 0) ? SLOT_GUARD : SLOT_LIT;

  // One copy of everything load_In captures.
  typedef struct packed {
    logic [4*NUM_DIGITS-1:0] bcd;
    logic [NUM_DIGITS-1:0]   dp;
    logic [NUM_DIGITS-1:0]   blank;
    logic [NUM_DIGITS-1:0]   blink;
  } disp_regs_t;

  function automatic logic [6:0] decode_hex(input logic [3:0] nib);
    logic [6:0] seg;
    seg = 7'h00;
    case (nib)
      4'h0:    seg = 7'h3F;
      4'h1:    seg = 7'h06;
      4'h2:    seg = 7'h5B;
      4'h3:    seg = 7'h4F;
      4'h4:    seg = 7'h66;
      4'h5:    seg = 7'h6D;
      4'h6:    seg = 7'h7D;
      4'h7:    seg = 7'h07;
      4'h8:    seg = 7'h7F;
      4'h9:    seg = 7'h6F;
      4'hA:    seg = 7'h77;
      4'hB:    seg = 7'h7C;
      4'hC:    seg = 7'h39;
      4'hD:    seg = 7'h5E;
      4'hE:    seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

  // State registers and their next-state values.
  slot_state_e             state_q, state_d;
  logic [SLOT_W-1:0]       slot_cnt_q, slot_cnt_d;
  logic [DIGIT_W-1:0]      digit_idx_q, digit_idx_d;
  logic [FRAME_W-1:0]      frame_cnt_q, frame_cnt_d;
  logic                    blink_phase_q, blink_phase_d;
  logic [BRIGHT_W-1:0]     pwm_cnt_q, pwm_cnt_d;
  disp_regs_t              shadow_q, shadow_d;
  disp_regs_t              active_q, active_d;
  logic [7:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    frame_q, frame_d;

  disp_regs_t              in_regs;
  logic                    slot_end;
  logic                    frame_wrap;
  logic [NUM_DIGITS-1:0]   lead_supp;

  assign in_regs    = '{bcd: bcd_In, dp: dp_In, blank: blank_In, blink: blink_In};
  assign slot_end   = (slot_cnt_q == SLOT_LAST);
  assign frame_wrap = slot_end && (digit_idx_q == DIGIT_LAST);

  // NOTE: every always_comb assigns all of its outputs a default first, so no
  // path through the block leaves a signal holding its old value (no latch).
  always_comb begin
    slot_cnt_d    = slot_cnt_q + 1'b1;
    digit_idx_d   = digit_idx_q;
    frame_cnt_d   = frame_cnt_q;
    blink_phase_d = blink_phase_q;
    pwm_cnt_d     = pwm_cnt_q + 1'b1;
    shadow_d      = shadow_q;
    active_d      = active_q;

    if (slot_end) begin
      slot_cnt_d  = '0;
      digit_idx_d = frame_wrap ? '0 : digit_idx_q + 1'b1;
    end

    if (frame_wrap) begin
      if (frame_cnt_q == FRAME_LAST) begin
        frame_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end

    if (load_In) begin
      shadow_d = in_regs;
    end

    // A load on the wrap cycle bypasses the shadow so it lands this frame.
    if (frame_wrap) begin
      active_d = load_In ? in_regs : shadow_q;
    end
  end

  // The slot FSM tracks the counter one step ahead, so state_q always agrees
  // with slot_cnt_q.
  always_comb begin
    state_d = (slot_cnt_d < GUARD_END) ? SLOT_GUARD : SLOT_LIT;
  end

`ifdef SVN_SEG_LEAD_ZERO_BLANK_EN
  // A digit is a leading zero when it and every digit above it hold 0.
  // Digit 0 is never suppressed, so an all-zero value still shows "0".
  always_comb begin
    logic upper_zero;
    upper_zero = 1'b1;
    lead_supp  = '0;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      upper_zero   = upper_zero && (active_q.bcd[4*k +: 4] == 4'h0);
      lead_supp[k] = upper_zero && !active_q.dp[k];
    end
  end
`else
  assign lead_supp = '0;
`endif

  // Output decode for the digit currently being scanned.
  always_comb begin
    logic [3:0]            nib;
    logic                  dp_bit;
    logic                  dark_bit;
    logic                  pwm_on;
    logic                  lit;
    logic [NUM_DIGITS-1:0] an_onehot;

    nib       = 4'h0;
    dp_bit    = 1'b0;
    dark_bit  = 1'b0;
    an_onehot = '0;

    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (digit_idx_q == DIGIT_W'(k)) begin
        nib          = active_q.bcd[4*k +: 4];
        dp_bit       = active_q.dp[k];
        dark_bit     = active_q.blank[k] || (active_q.blink[k] && blink_phase_q) ||
                       lead_supp[k];
        an_onehot[k] = 1'b1;
      end
    end

    pwm_on = (&brightness_In) || (pwm_cnt_q < brightness_In);
    lit    = (state_q == SLOT_LIT) && display_On && !dark_bit && pwm_on;

    seg_d   = lit ? {dp_bit, decode_hex(nib)} : 8'h00;
    an_d    = lit ? an_onehot : '0;
    frame_d = frame_wrap;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  // NOTE: shadow and active are flops, not a RAM, so they are reset along with
  // the counters and the display comes up showing zeros rather than garbage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= STATE_RST;
      slot_cnt_q    <= '0;
      digit_idx_q   <= '0;
      frame_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      pwm_cnt_q     <= '0;
      shadow_q      <= '0;
      active_q      <= '0;
      seg_q         <= 8'h00;
      an_q          <= '0;
      frame_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      slot_cnt_q    <= slot_cnt_d;
      digit_idx_q   <= digit_idx_d;
      frame_cnt_q   <= frame_cnt_d;
      blink_phase_q <= blink_phase_d;
      pwm_cnt_q     <= pwm_cnt_d;
      shadow_q      <= shadow_d;
      active_q      <= active_d;
      seg_q         <= seg_d;
      an_q          <= an_d;
      frame_q       <= frame_d;
    end
  end

  assign seg_Out   = seg_q;
  assign an_Out    = an_q;
  assign frame_Out = frame_q;

endmodule
